// File: rtl/mm_seq_top_if.sv
// Command, BRAM and FIOS-core signal bundle for the Montgomery multiply sequencer.
// The slave view belongs to the sequencer; the master view to whatever drives it.
interface mm_seq_top_if #(
  parameter int unsigned W  = 17,
  parameter int unsigned s  = 8,
  parameter int unsigned AW = 32
);
  logic            start_i;
  logic [1:0]      mode_i;
  logic [7:0]      rep_i;
  logic [W-1:0]    BRAM_dout_i;
  logic [W-1:0]    BRAM_din_o;
  logic            BRAM_we_o;
  logic            BRAM_en_o;
  logic [AW-1:0]   BRAM_addr_o;
  logic            core_start_o;
  logic            core_done_i;
  logic [W-1:0]    core_pp0_o;
  logic [s*W-1:0]  core_a_o;
  logic [W-1:0]    core_b_o;
  logic [W-1:0]    core_p_o;
  logic            core_b_fetch_i;
  logic            core_p_fetch_i;
  logic            core_res_push_i;
  logic [W-1:0]    core_res_i;
  logic            busy_o;
  logic            done_o;
  logic            err_o;

  modport slave (
    input  start_i, mode_i, rep_i, BRAM_dout_i, core_done_i,
           core_b_fetch_i, core_p_fetch_i, core_res_push_i, core_res_i,
    output BRAM_din_o, BRAM_we_o, BRAM_en_o, BRAM_addr_o, core_start_o,
           core_pp0_o, core_a_o, core_b_o, core_p_o, busy_o, done_o, err_o
  );

  modport master (
    output start_i, mode_i, rep_i, BRAM_dout_i, core_done_i,
           core_b_fetch_i, core_p_fetch_i, core_res_push_i, core_res_i,
    input  BRAM_din_o, BRAM_we_o, BRAM_en_o, BRAM_addr_o, core_start_o,
           core_pp0_o, core_a_o, core_b_o, core_p_o, busy_o, done_o, err_o
  );
endinterface

// File: rtl/mm_seq_top.sv
// Operand sequencer around a FIOS Montgomery core: loads p', p, a, b from BRAM,
// runs the core rep times (chaining the result), and writes the result back.
module mm_seq_top #(
  parameter int unsigned W  = 17,
  parameter int unsigned s  = 8,
  parameter int unsigned AW = 32
) (
  input  logic        clock_i,
  input  logic        reset_i,
  mm_seq_top_if.slave bus
);

  localparam int unsigned SW = s * W;
  localparam int unsigned IW = $clog2(4 * s + 1);

  localparam logic [IW-1:0] A_A0 = IW'(s + 1);
  localparam logic [IW-1:0] A_B0 = IW'(2 * s + 1);
  localparam logic [IW-1:0] A_B1 = IW'(3 * s);
  localparam logic [IW-1:0] A_R0 = IW'(3 * s + 1);
  localparam logic [IW-1:0] A_R1 = IW'(4 * s);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RUN, S_WAIT, S_COPY, S_WB, S_DONE
  } state_t;

  state_t        r_state;
  logic [1:0]    r_mode;
  logic [7:0]    r_rep_left;
  logic [W-1:0]  r_pp0;
  logic [SW-1:0] r_p;
  logic [SW-1:0] r_a;
  logic [SW-1:0] r_b;
  logic [SW-1:0] r_res;
  logic [SW-1:0] r_shadow;
  logic [W-1:0]  r_dout;
  logic          r_ld_v;
  logic [IW-1:0] r_ld_addr;
  logic [IW-1:0] r_addr;
  logic          r_en;
  logic          r_we;
  logic [W-1:0]  r_din;
  logic          r_core_start;
  logic          r_busy;
  logic          r_done;
  logic          r_err;

  logic [SW-1:0] w_res_next;

  // Result register as it will be after this cycle's push, so a push that
  // coincides with core_done still reaches the write-back copy.
  always_comb begin
    w_res_next = r_res;
    if (bus.core_res_push_i) w_res_next = {bus.core_res_i, r_res[SW-1:W]};
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_state      <= S_IDLE;
      r_mode       <= '0;
      r_rep_left   <= '0;
      r_pp0        <= '0;
      r_p          <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_res        <= '0;
      r_shadow     <= '0;
      r_dout       <= '0;
      r_ld_v       <= 1'b0;
      r_ld_addr    <= '0;
      r_addr       <= '0;
      r_en         <= 1'b0;
      r_we         <= 1'b0;
      r_din        <= '0;
      r_core_start <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_core_start <= 1'b0;
      r_done       <= 1'b0;

      // Read pipeline: data registered once, landed in its operand a cycle later.
      r_dout    <= bus.BRAM_dout_i;
      r_ld_v    <= r_en & ~r_we;
      r_ld_addr <= r_addr;
      if (r_ld_v) begin
        if (r_ld_addr == '0)       r_pp0 <= r_dout;
        else if (r_ld_addr < A_A0) r_p   <= {r_dout, r_p[SW-1:W]};
        else if (r_ld_addr < A_B0) r_a   <= {r_dout, r_a[SW-1:W]};
        else                       r_b   <= {r_dout, r_b[SW-1:W]};
      end

      case (r_state)
        S_IDLE: begin
          if (bus.start_i) begin
            r_mode     <= bus.mode_i;
            r_rep_left <= (bus.rep_i == 8'd0) ? 8'd1 : bus.rep_i;
            r_busy     <= 1'b1;
            r_err      <= 1'b0;
            case (bus.mode_i)
              2'd0: begin
                r_addr  <= '0;
                r_en    <= 1'b1;
                r_state <= S_LOAD;
              end
              2'd1: begin
                r_addr  <= A_B0;
                r_en    <= 1'b1;
                r_state <= S_LOAD;
              end
              2'd2: begin
                r_a          <= r_res;
                r_b          <= r_res;
                r_core_start <= 1'b1;
                r_state      <= S_RUN;
              end
              default: begin
                r_err   <= 1'b1;
                r_done  <= 1'b1;
                r_state <= S_DONE;
              end
            endcase
          end
        end

        S_LOAD: begin
          if (r_mode == 2'd1 && r_en && r_addr == A_B0) r_a <= r_res;
          if (r_en) begin
            if (r_addr == A_B1) r_en   <= 1'b0;
            else                r_addr <= r_addr + IW'(1);
          end else begin
            // Drain cycle: the final word lands at this edge.
            r_core_start <= 1'b1;
            r_state      <= S_RUN;
          end
        end

        S_RUN: r_state <= S_WAIT;

        S_WAIT: begin
          if (bus.core_b_fetch_i) r_b <= {r_b[W-1:0], r_b[SW-1:W]};
          if (bus.core_p_fetch_i) r_p <= {r_p[W-1:0], r_p[SW-1:W]};
          r_res <= w_res_next;
          if (bus.core_done_i) begin
            r_rep_left <= r_rep_left - 8'd1;
            if (r_rep_left <= 8'd1) begin
              r_en     <= 1'b1;
              r_we     <= 1'b1;
              r_addr   <= A_R0;
              r_din    <= w_res_next[W-1:0];
              r_shadow <= {W'(0), w_res_next[SW-1:W]};
              r_state  <= S_WB;
            end else begin
              r_state <= S_COPY;
            end
          end
        end

        S_COPY: begin
          r_a <= r_res;
          if (r_mode == 2'd2) r_b <= r_res;
          r_core_start <= 1'b1;
          r_state      <= S_RUN;
        end

        S_WB: begin
          if (r_addr == A_R1) begin
            r_en    <= 1'b0;
            r_we    <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_addr   <= r_addr + IW'(1);
            r_din    <= r_shadow[W-1:0];
            r_shadow <= {W'(0), r_shadow[SW-1:W]};
          end
        end

        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.BRAM_din_o   = r_din;
  assign bus.BRAM_we_o    = r_we;
  assign bus.BRAM_en_o    = r_en;
  assign bus.BRAM_addr_o  = AW'(r_addr);
  assign bus.core_start_o = r_core_start;
  assign bus.core_pp0_o   = r_pp0;
  assign bus.core_a_o     = r_a;
  assign bus.core_b_o     = r_b[W-1:0];
  assign bus.core_p_o     = r_p[W-1:0];
  assign bus.busy_o       = r_busy;
  assign bus.done_o       = r_done;
  assign bus.err_o        = r_err;

endmodule
